aes_key_expand_multi: RTL and testbench

Parametrised, multi-key-length AES key-schedule engine supporting AES-128, AES-192 and AES-256. It loads the cipher key as 32-bit words over a valid/ready handshake and generates the full FIPS-197 expanded schedule sequentially, one word per cycle, into internal word storage. The cipher datapath then reads any 32-bit word of any round key through a registered read port. It replaces the fixed AES-128 key expander in the encryption core.

---
 rtl/aes_key_expand_multi.sv | 162 ++++++++++++++++
 tb/tb_aes_key_expand_multi.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_multi.sv
// Multi-length AES key schedule: loads Nk key words, then expands the full
// FIPS-197 schedule one word per cycle into a flat word store read by round/word.
module aes_key_expand_multi #(
    parameter int MAX_NK = 8,
    parameter int RD_REG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  key_len,
    input  logic [31:0] key_in,
    input  logic        key_in_valid,
    output logic        key_in_ready,
    input  logic [3:0]  rd_round,
    input  logic [1:0]  rd_word,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  nr
);
    localparam int DEPTH = 4 * (MAX_NK + 7);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] w_mem [DEPTH];
    logic [3:0]  nk_q, nr_q, nk_sel, nr_sel, mod_cnt;
    logic [5:0]  idx, last_key, last_idx, rd_addr;
    logic [7:0]  rcon;
    logic        err_q, legal, mem_we;
    logic [31:0] prev_w, back_w, temp_w, new_w, mem_wdata, rd_mux;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        nk_sel = 4'd0;
        nr_sel = 4'd0;
        case (key_len)
            2'd0:    begin nk_sel = 4'd4; nr_sel = 4'd10; end
            2'd1:    begin nk_sel = 4'd6; nr_sel = 4'd12; end
            2'd2:    begin nk_sel = 4'd8; nr_sel = 4'd14; end
            default: begin nk_sel = 4'd0; nr_sel = 4'd0;  end
        endcase
        legal = (key_len != 2'd3) && (nk_sel <= 4'(MAX_NK));
    end

    assign last_key = {2'b00, nk_q} - 6'd1;
    assign last_idx = {nr_q, 2'b11};

    // w[i] = w[i-Nk] ^ f(w[i-1]); mod_cnt tracks i mod Nk without a divider
    always_comb begin
        prev_w = w_mem[idx - 6'd1];
        back_w = w_mem[idx - {2'b00, nk_q}];
        temp_w = prev_w;
        if (mod_cnt == 4'd0)
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h0};
        else if (nk_q == 4'd8 && mod_cnt == 4'd4)
            temp_w = sub_word(prev_w);
        new_w = back_w ^ temp_w;
    end

    // start overrides any in-flight handshake or expansion step
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_wdata = key_in;
        if (start) begin
            state_nxt = legal ? LOAD : IDLE;
        end else begin
            case (state)
                LOAD: begin
                    if (key_in_valid) begin
                        mem_we = 1'b1;
                        if (idx == last_key) state_nxt = EXPAND;
                    end
                end
                EXPAND: begin
                    mem_we    = 1'b1;
                    mem_wdata = new_w;
                    if (idx == last_idx) state_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            idx     <= 6'd0;
            mod_cnt <= 4'd0;
            rcon    <= 8'h00;
            err_q   <= 1'b0;
        end else if (start) begin
            idx <= 6'd0;
            if (legal) begin
                nk_q  <= nk_sel;
                nr_q  <= nr_sel;
                err_q <= 1'b0;
            end else begin
                err_q <= 1'b1;
            end
        end else if (mem_we) begin
            idx <= idx + 6'd1;
            if (state == LOAD) begin
                mod_cnt <= 4'd0;
                rcon    <= 8'h01;
            end else begin
                mod_cnt <= (mod_cnt == nk_q - 4'd1) ? 4'd0 : mod_cnt + 4'd1;
                if (mod_cnt == 4'd0) rcon <= xtime(rcon);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) w_mem[idx] <= mem_wdata;
    end

    assign rd_addr = {rd_round, rd_word};
    assign rd_mux  = (rd_round > nr_q) ? 32'h0 : w_mem[rd_addr];

    generate
        if (RD_REG != 0) begin : g_rd_reg
            always_ff @(posedge clk) begin
                if (reset) rd_data <= 32'h0;
                else       rd_data <= rd_mux;
            end
        end else begin : g_rd_comb
            assign rd_data = rd_mux;
        end
    endgenerate

    assign key_in_ready = (state == LOAD);
    assign busy         = (state == LOAD) || (state == EXPAND);
    assign done         = (state == DONE);
    assign err          = err_q;
    assign nr           = nr_q;
endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Directed + random bench for aes_key_expand_multi against a FIPS-197 model
// whose S-box and Rcon are derived from GF(2^8) arithmetic.
module tb_aes_key_expand_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  key_len = 2'd0;
    logic [31:0] key_in = 32'h0;
    logic        key_in_valid = 1'b0;
    logic        key_in_ready;
    logic [3:0]  rd_round = 4'd0;
    logic [1:0]  rd_word = 2'd0;
    logic [31:0] rd_data;
    logic        busy, done, err;
    logic [3:0]  nr;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  sb [256];
    logic [7:0]  rc [10];
    logic [31:0] key_w [8];
    logic [31:0] ref_w [60];
    int          stall_before [8];
    logic [31:0] d;
    int          lat;

    aes_key_expand_multi #(.MAX_NK(8), .RD_REG(1)) dut (
        .clk(clk), .reset(reset), .start(start), .key_len(key_len),
        .key_in(key_in), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
        .rd_round(rd_round), .rd_word(rd_word), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .nr(nr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h01;
        for (int j = 1; j < 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
    endtask

    task automatic model_expand(input int nk);
        logic [31:0] t;
        int total = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) ref_w[i] = key_w[i];
        for (int i = nk; i < total; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk - 1], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ready"}, {31'd0, key_in_ready}, 32'd0);
        check({tag, " busy"},  {31'd0, busy}, 32'd0);
        check({tag, " done"},  {31'd0, done}, 32'd0);
        check({tag, " err"},   {31'd0, err}, 32'd0);
        check({tag, " nr"},    {28'd0, nr}, 32'd0);
        check({tag, " rd_data"}, rd_data, 32'd0);
    endtask

    // Called right after a negedge; returns right after a negedge.
    task automatic read_word(input int r, input int k, output logic [31:0] q);
        rd_round = 4'(r);
        rd_word  = 2'(k);
        @(negedge clk);
        q = rd_data;
    endtask

    // Pulses start (with a junk word offered alongside) and feeds cnt key words.
    task automatic load_words(input logic [1:0] kl, input int cnt, output int n);
        start = 1'b1;
        key_len = kl;
        key_in_valid = 1'b1;
        key_in = $urandom;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("load done_low", {31'd0, done}, 32'd0);
        check("load ready", {31'd0, key_in_ready}, 32'd1);
        check("load busy", {31'd0, busy}, 32'd1);
        check("load err_clear", {31'd0, err}, 32'd0);
        for (int j = 0; j < cnt; j++) begin
            for (int s = 0; s < stall_before[j]; s++) begin
                key_in_valid = 1'b0;
                @(negedge clk);
                n++;
            end
            key_in_valid = 1'b1;
            key_in = key_w[j];
            @(negedge clk);
            n++;
        end
        key_in_valid = 1'b0;
    endtask

    task automatic run_key(input logic [1:0] kl, input int nk, output int n);
        load_words(kl, nk, n);
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_sched(input string tag, input int nk);
        model_expand(nk);
        check({tag, " nr"}, {28'd0, nr}, 32'(nk + 6));
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            read_word(i / 4, i % 4, d);
            check($sformatf("%s w%0d", tag, i), d, ref_w[i]);
        end
    endtask

    initial begin
        int n;
        build_tables();
        for (int j = 0; j < 8; j++) stall_before[j] = 0;

        // reset values
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // AES-128 FIPS-197 A.1
        key_w = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                  32'h0, 32'h0, 32'h0, 32'h0};
        run_key(2'd0, 4, lat);
        check("a1 latency", lat, 32'd45);
        check("a1 busy_low", {31'd0, busy}, 32'd0);
        read_word(1, 0, d);  check("a1 w4", d, 32'ha0fafe17);
        read_word(10, 0, d); check("a1 r10w0", d, 32'hd014f9a8);
        read_word(10, 1, d); check("a1 r10w1", d, 32'hc9ee2589);
        read_word(10, 2, d); check("a1 r10w2", d, 32'he13f0cc8);
        read_word(10, 3, d); check("a1 r10w3", d, 32'hb6630ca6);
        read_word(11, 0, d); check("a1 r11", d, 32'h0);
        read_word(15, 3, d); check("a1 r15", d, 32'h0);
        check_sched("a1", 4);

        // AES-192 A.2
        key_w = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                  32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0};
        run_key(2'd1, 6, lat);
        check("a2 latency", lat, 32'd53);
        read_word(1, 2, d);  check("a2 w6", d, 32'hfe0c91f7);
        read_word(12, 3, d); check("a2 w51", d, 32'h01002202);
        read_word(13, 0, d); check("a2 r13", d, 32'h0);
        check_sched("a2", 6);

        // AES-256 A.3
        key_w = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                  32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        run_key(2'd2, 8, lat);
        check("a3 latency", lat, 32'd61);
        read_word(2, 0, d);  check("a3 w8", d, 32'h9ba35411);
        read_word(3, 0, d);  check("a3 w12", d, 32'ha8b09c1a);
        read_word(14, 3, d); check("a3 w59", d, 32'h706c631e);
        check_sched("a3", 8);

        // random keys in every mode
        for (int m = 0; m < 3; m++) begin
            for (int j = 0; j < 8; j++) key_w[j] = $urandom;
            run_key(2'(m), 4 + 2 * m, lat);
            check($sformatf("rand%0d latency", m), lat, 32'(4 * (4 + 2 * m + 7) + 1));
            check_sched($sformatf("rand%0d", m), 4 + 2 * m);
        end

        // handshake stall: 3 idle cycles spread between A.1 words
        key_w = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                  32'h0, 32'h0, 32'h0, 32'h0};
        for (int s = 0; s < 3; s++) stall_before[$urandom_range(1, 3)]++;
        run_key(2'd0, 4, lat);
        for (int j = 0; j < 8; j++) stall_before[j] = 0;
        check("stall latency", lat, 32'd48);
        check_sched("stall", 4);

        // abort mid-EXPAND of AES-256, then A.1
        key_w = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                  32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        load_words(2'd2, 8, n);
        repeat (10) @(negedge clk);
        check("abort exp busy", {31'd0, busy}, 32'd1);
        check("abort exp done", {31'd0, done}, 32'd0);
        key_w = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                  32'h0, 32'h0, 32'h0, 32'h0};
        run_key(2'd0, 4, lat);
        check("abort latency", lat, 32'd45);
        read_word(10, 0, d); check("abort r10w0", d, 32'hd014f9a8);
        read_word(10, 3, d); check("abort r10w3", d, 32'hb6630ca6);
        read_word(11, 0, d); check("abort r11", d, 32'h0);

        // abort mid-LOAD of AES-192; restart start cycle also offers a word
        for (int j = 0; j < 8; j++) key_w[j] = $urandom;
        load_words(2'd1, 3, n);
        for (int j = 0; j < 8; j++) key_w[j] = $urandom;
        run_key(2'd0, 4, lat);
        check("reload latency", lat, 32'd45);
        check_sched("reload", 4);

        // illegal key length from DONE
        start = 1'b1;
        key_len = 2'd3;
        @(negedge clk);
        start = 1'b0;
        check("illegal err", {31'd0, err}, 32'd1);
        check("illegal busy", {31'd0, busy}, 32'd0);
        check("illegal done", {31'd0, done}, 32'd0);
        check("illegal ready", {31'd0, key_in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("illegal err_sticky", {31'd0, err}, 32'd1);

        // reset mid-LOAD
        for (int j = 0; j < 8; j++) key_w[j] = $urandom;
        load_words(2'd0, 2, n);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midload_reset");
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
